// File: rtl/stage_work_scheduler.sv
// Multi-stage work queue: one FIFO of register snapshots per pipeline stage,
// arbitrated onto a single grant port for the shader processor.
module stage_work_scheduler #(
    parameter int  NUM_STAGES = 4,
    parameter int  DATA_W     = 256,
    parameter int  DEPTH      = 16,
    parameter int  PC_W       = 16,
    parameter int  RR_MODE    = 0,
    localparam int SW         = $clog2(NUM_STAGES),
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_STAGES*PC_W-1:0] stage_pc,
    input  logic                       enq_valid,
    input  logic [SW-1:0]              enq_stage,
    input  logic [DATA_W-1:0]          enq_data,
    output logic                       enq_ready,
    input  logic                       req,
    output logic                       grant_valid,
    output logic [SW-1:0]              grant_stage,
    output logic [PC_W-1:0]            grant_pc,
    output logic [DATA_W-1:0]          grant_data,
    output logic                       busy,
    output logic [NUM_STAGES*CW-1:0]   occupancy,
    output logic                       err
);
    typedef enum logic [1:0] {IDLE, PICK, RESP} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0]     mem   [NUM_STAGES][DEPTH];
    logic [AW-1:0]         head  [NUM_STAGES];
    logic [AW-1:0]         tail  [NUM_STAGES];
    logic [CW-1:0]         count [NUM_STAGES];
    logic [SW-1:0]         last_granted;
    logic [SW-1:0]         win;
    logic [SW-1:0]         pick_stage;
    logic [PC_W-1:0]       pick_pc;
    logic [DATA_W-1:0]     pick_data;
    logic [NUM_STAGES-1:0] enq_hit;
    logic [NUM_STAGES-1:0] nonempty;
    logic                  enq_acc;
    logic                  pop;
    int                    scan;

    // Out-of-range enq_stage matches no queue, so it is never ready.
    always_comb begin
        enq_hit   = '0;
        nonempty  = '0;
        enq_ready = 1'b0;
        occupancy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            nonempty[i]            = (count[i] != '0);
            enq_hit[i]             = (enq_stage == SW'(i));
            occupancy[i*CW +: CW]  = count[i];
            if (enq_hit[i] && (count[i] != CW'(DEPTH))) enq_ready = 1'b1;
        end
    end

    assign enq_acc = enq_valid && enq_ready;
    assign pop     = (state == IDLE) && req && (|nonempty);

    // Round robin walks the scan order backwards so the first hit in scan order is written last.
    always_comb begin
        win  = '0;
        scan = 0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (nonempty[i]) win = SW'(i);
            end
        end else begin
            for (int k = NUM_STAGES; k >= 1; k--) begin
                scan = int'(last_granted) - k;
                if (scan < 0) scan = scan + NUM_STAGES;
                if (nonempty[scan]) win = SW'(scan);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = PICK;
            PICK:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_valid = (state == RESP);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (enq_acc && enq_hit[i]) mem[i][tail[i]] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            err          <= 1'b0;
            last_granted <= '0;
            pick_stage   <= '0;
            pick_pc      <= '0;
            pick_data    <= '0;
            grant_stage  <= '0;
            grant_pc     <= '0;
            grant_data   <= '0;
        end else begin
            if (enq_valid && !enq_ready) err <= 1'b1;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (enq_acc && enq_hit[i])      tail[i] <= tail[i] + AW'(1);
                if (pop && (win == SW'(i)))     head[i] <= head[i] + AW'(1);
                count[i] <= count[i] + CW'(enq_acc && enq_hit[i]) - CW'(pop && (win == SW'(i)));
            end
            if (pop) begin
                pick_stage   <= win;
                pick_pc      <= stage_pc[win*PC_W +: PC_W];
                pick_data    <= mem[win][head[win]];
                last_granted <= win;
            end
            if (state == PICK) begin
                grant_stage <= pick_stage;
                grant_pc    <= pick_pc;
                grant_data  <= pick_data;
            end
        end
    end
endmodule

// File: tb/tb_stage_work_scheduler.sv
// Directed bench: a 3-stage fixed-priority instance (a_*) and a 4-stage round-robin instance (b_*).
module tb_stage_work_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [47:0] a_stage_pc;
    logic        a_enq_valid, a_enq_ready, a_req, a_grant_valid, a_busy, a_err;
    logic [1:0]  a_enq_stage, a_grant_stage;
    logic [31:0] a_enq_data, a_grant_data;
    logic [15:0] a_grant_pc;
    logic [8:0]  a_occupancy;
    logic [15:0] a_pc_tab [3] = '{16'h0100, 16'h0200, 16'h0300};

    logic [63:0] b_stage_pc;
    logic        b_enq_valid, b_enq_ready, b_req, b_grant_valid, b_busy, b_err;
    logic [1:0]  b_enq_stage, b_grant_stage;
    logic [31:0] b_enq_data, b_grant_data;
    logic [15:0] b_grant_pc;
    logic [11:0] b_occupancy;
    logic [15:0] b_pc_tab [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};

    stage_work_scheduler #(.NUM_STAGES(3), .DATA_W(32), .DEPTH(4), .PC_W(16), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .stage_pc(a_stage_pc), .enq_valid(a_enq_valid), .enq_stage(a_enq_stage),
        .enq_data(a_enq_data), .enq_ready(a_enq_ready), .req(a_req), .grant_valid(a_grant_valid),
        .grant_stage(a_grant_stage), .grant_pc(a_grant_pc), .grant_data(a_grant_data), .busy(a_busy),
        .occupancy(a_occupancy), .err(a_err)
    );

    stage_work_scheduler #(.NUM_STAGES(4), .DATA_W(32), .DEPTH(4), .PC_W(16), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .stage_pc(b_stage_pc), .enq_valid(b_enq_valid), .enq_stage(b_enq_stage),
        .enq_data(b_enq_data), .enq_ready(b_enq_ready), .req(b_req), .grant_valid(b_grant_valid),
        .grant_stage(b_grant_stage), .grant_pc(b_grant_pc), .grant_data(b_grant_data), .busy(b_busy),
        .occupancy(b_occupancy), .err(b_err)
    );

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic a_enq(input logic [1:0] stage, input logic [31:0] data, input logic exp_rdy, input string name);
        @(posedge clk); #1;
        a_enq_valid = 1'b1; a_enq_stage = stage; a_enq_data = data;
        @(negedge clk);
        checks++;
        if (a_enq_ready !== exp_rdy) begin failures++; $display("FAIL %s_ready: got %b expected %b", name, a_enq_ready, exp_rdy); end
        @(posedge clk); #1;
        a_enq_valid = 1'b0;
    endtask

    task automatic b_enq(input logic [1:0] stage, input logic [31:0] data);
        @(posedge clk); #1;
        b_enq_valid = 1'b1; b_enq_stage = stage; b_enq_data = data;
        @(negedge clk);
        checks++;
        if (b_enq_ready !== 1'b1) begin failures++; $display("FAIL rr_enq_ready: got %b expected 1", b_enq_ready); end
        @(posedge clk); #1;
        b_enq_valid = 1'b0;
    endtask

    // Raises req (optionally with a concurrent enqueue) and returns at the negedge of the RESP cycle.
    task automatic a_get(input logic do_enq, input logic [1:0] estage, input logic [31:0] edata, input logic exp_rdy,
                         input int exp_lat, input int exp_stage, input logic [31:0] exp_data, input string name);
        int n   = 0;
        bit got = 0;
        @(posedge clk); #1;
        a_req = 1'b1;
        if (do_enq) begin a_enq_valid = 1'b1; a_enq_stage = estage; a_enq_data = edata; end
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (do_enq && n == 1) begin
                checks++;
                if (a_enq_ready !== exp_rdy) begin failures++; $display("FAIL %s_ready: got %b expected %b", name, a_enq_ready, exp_rdy); end
            end
            if (a_grant_valid === 1'b1) got = 1;
            else begin @(posedge clk); #1; a_enq_valid = 1'b0; end
        end
        a_req = 1'b0; a_enq_valid = 1'b0;
        checks++;
        if (!got) begin failures++; $display("FAIL %s_timeout: no grant after %0d cycles", name, n); end
        else begin
            checks++;
            if (n !== exp_lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_lat); end
            checks++;
            if (a_grant_stage !== 2'(exp_stage)) begin failures++; $display("FAIL %s_stage: got %0d expected %0d", name, a_grant_stage, exp_stage); end
            checks++;
            if (a_grant_pc !== a_pc_tab[exp_stage]) begin failures++; $display("FAIL %s_pc: got %h expected %h", name, a_grant_pc, a_pc_tab[exp_stage]); end
            checks++;
            if (a_grant_data !== exp_data) begin failures++; $display("FAIL %s_data: got %h expected %h", name, a_grant_data, exp_data); end
        end
    endtask

    task automatic b_get(input int exp_stage, input logic [31:0] exp_data, input string name);
        int n   = 0;
        bit got = 0;
        @(posedge clk); #1;
        b_req = 1'b1;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (b_grant_valid === 1'b1) got = 1;
            else begin @(posedge clk); #1; end
        end
        b_req = 1'b0;
        checks++;
        if (!got) begin failures++; $display("FAIL %s_timeout: no grant after %0d cycles", name, n); end
        else begin
            checks++;
            if (n !== 3) begin failures++; $display("FAIL %s_latency: got %0d expected 3", name, n); end
            checks++;
            if (b_grant_stage !== 2'(exp_stage)) begin failures++; $display("FAIL %s_stage: got %0d expected %0d", name, b_grant_stage, exp_stage); end
            checks++;
            if (b_grant_pc !== b_pc_tab[exp_stage]) begin failures++; $display("FAIL %s_pc: got %h expected %h", name, b_grant_pc, b_pc_tab[exp_stage]); end
            checks++;
            if (b_grant_data !== exp_data) begin failures++; $display("FAIL %s_data: got %h expected %h", name, b_grant_data, exp_data); end
        end
    endtask

    task automatic test_reset;
        bit pulsed = 0;
        @(negedge clk);
        checks++;
        if ({a_grant_valid, a_busy, a_err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {a_grant_valid, a_busy, a_err}); end
        checks++;
        if ({a_occupancy, b_occupancy} !== 21'h0) begin failures++; $display("FAIL reset_occupancy: got %h expected 0", {a_occupancy, b_occupancy}); end
        checks++;
        if ({a_grant_stage, a_grant_pc, a_grant_data} !== 50'h0) begin failures++; $display("FAIL reset_grant: got %h expected 0", {a_grant_stage, a_grant_pc, a_grant_data}); end
        a_enq(2'd1, 32'h5555_0001, 1'b1, "rst_enq");
        a_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1) begin failures++; $display("FAIL rst_pick_busy: got %b expected 1", a_busy); end
        checks++;
        if (a_occupancy !== 9'h0) begin failures++; $display("FAIL pick_occupancy: got %h expected 0", a_occupancy); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            if (a_grant_valid !== 1'b0) pulsed = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_grant_valid !== 1'b0) pulsed = 1;
        end
        checks++;
        if (pulsed !== 1'b0) begin failures++; $display("FAIL rst_mid_pick_grant: got pulse expected none"); end
        checks++;
        if ({a_busy, a_err, a_occupancy, a_grant_data} !== 43'h0) begin failures++; $display("FAIL rst_mid_pick_state: got %h expected 0", {a_busy, a_err, a_occupancy, a_grant_data}); end
    endtask

    task automatic test_fixed_priority;
        do_reset();
        a_enq(2'd0, 32'hAAAA_0000, 1'b1, "fp_enq_a");
        a_enq(2'd2, 32'hBBBB_0002, 1'b1, "fp_enq_b");
        a_enq(2'd1, 32'hCCCC_0001, 1'b1, "fp_enq_c");
        @(negedge clk);
        checks++;
        if (a_occupancy !== 9'b001_001_001) begin failures++; $display("FAIL fp_occupancy: got %b expected 001001001", a_occupancy); end
        a_get(1'b0, 2'd0, 32'h0, 1'b0, 3, 2, 32'hBBBB_0002, "fp_first");
        @(posedge clk); @(negedge clk);
        checks++;
        if ({a_grant_valid, a_busy} !== 2'b00) begin failures++; $display("FAIL fp_after_resp: got %b expected 00", {a_grant_valid, a_busy}); end
        checks++;
        if ({a_grant_stage, a_grant_pc, a_grant_data} !== {2'd2, 16'h0300, 32'hBBBB_0002}) begin
            failures++; $display("FAIL fp_hold: got %h expected %h", {a_grant_stage, a_grant_pc, a_grant_data}, {2'd2, 16'h0300, 32'hBBBB_0002});
        end
        checks++;
        if (a_occupancy !== 9'b000_001_001) begin failures++; $display("FAIL fp_pop_only_winner: got %b expected 000001001", a_occupancy); end
        a_get(1'b0, 2'd0, 32'h0, 1'b0, 3, 1, 32'hCCCC_0001, "fp_second");
        a_get(1'b0, 2'd0, 32'h0, 1'b0, 3, 0, 32'hAAAA_0000, "fp_third");
    endtask

    task automatic test_bad_index;
        do_reset();
        a_enq(2'd3, 32'hBAD0_0003, 1'b0, "bad_index");
        @(negedge clk);
        checks++;
        if ({a_err, a_occupancy} !== 10'b1_000000000) begin failures++; $display("FAIL bad_index_err: got %b expected 1000000000", {a_err, a_occupancy}); end
    endtask

    task automatic test_overflow;
        do_reset();
        @(negedge clk);
        checks++;
        if (a_err !== 1'b0) begin failures++; $display("FAIL ovf_err_clear: got %b expected 0", a_err); end
        for (int i = 0; i < 5; i++) a_enq(2'd1, 32'h0000_0011 + i, (i < 4), "ovf_enq");
        @(negedge clk);
        checks++;
        if (a_err !== 1'b1) begin failures++; $display("FAIL ovf_err_set: got %b expected 1", a_err); end
        checks++;
        if (a_occupancy !== 9'b000_100_000) begin failures++; $display("FAIL ovf_occupancy: got %b expected 000100000", a_occupancy); end
        for (int i = 0; i < 4; i++) a_get(1'b0, 2'd0, 32'h0, 1'b0, 3, 1, 32'h0000_0011 + i, "ovf_pop");
        @(posedge clk); @(negedge clk);
        checks++;
        if ({a_err, a_occupancy} !== 10'b1_000000000) begin failures++; $display("FAIL ovf_drain: got %b expected 1000000000", {a_err, a_occupancy}); end
    endtask

    task automatic test_wrap_simul;
        int nxt_in  = 0;
        int nxt_out = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_enq(2'd0, 32'hD000_0000 + nxt_in, 1'b1, "wrap_fill");
            nxt_in++;
        end
        for (int r = 0; r < 7; r++) begin
            a_get(1'b1, 2'd0, 32'hD000_0000 + nxt_in, 1'b1, 3, 0, 32'hD000_0000 + nxt_out, "wrap_simul");
            nxt_in++; nxt_out++;
            checks++;
            if (a_occupancy !== 9'd3) begin failures++; $display("FAIL wrap_count: got %0d expected 3", a_occupancy); end
        end
        a_enq(2'd0, 32'hD000_0000 + nxt_in, 1'b1, "wrap_top");
        nxt_in++;
        @(negedge clk);
        checks++;
        if ({a_err, a_occupancy} !== 10'd4) begin failures++; $display("FAIL wrap_full: got %b expected 0000000100", {a_err, a_occupancy}); end
        a_get(1'b1, 2'd0, 32'hDEAD_DEAD, 1'b0, 3, 0, 32'hD000_0000 + nxt_out, "full_simul");
        nxt_out++;
        checks++;
        if ({a_err, a_occupancy} !== 10'b1_000000011) begin failures++; $display("FAIL full_simul_drop: got %b expected 1000000011", {a_err, a_occupancy}); end
        for (int i = 0; i < 3; i++) begin
            a_get(1'b0, 2'd0, 32'h0, 1'b0, 3, 0, 32'hD000_0000 + nxt_out, "wrap_drain");
            nxt_out++;
        end
        checks++;
        if (a_occupancy !== 9'd0) begin failures++; $display("FAIL wrap_empty: got %0d expected 0", a_occupancy); end
    endtask

    task automatic test_empty_wait;
        bit bad = 0;
        do_reset();
        @(posedge clk); #1;
        a_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({a_grant_valid, a_busy} !== 2'b00) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL empty_wait: got grant or busy expected idle"); end
        a_get(1'b1, 2'd1, 32'hE000_0001, 1'b1, 4, 1, 32'hE000_0001, "empty_then_enq");
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 2; k++) b_enq(2'(s), 32'hB000_0000 + s * 16 + k);
        @(negedge clk);
        checks++;
        if (b_occupancy !== 12'b010_010_010_010) begin failures++; $display("FAIL rr_occupancy: got %b expected 010010010010", b_occupancy); end
        for (int r = 0; r < 8; r++) b_get(3 - (r % 4), 32'hB000_0000 + (3 - (r % 4)) * 16 + r / 4, "rr_order");
        b_enq(2'd0, 32'hB000_0100);
        b_enq(2'd2, 32'hB000_0120);
        b_enq(2'd2, 32'hB000_0121);
        b_get(2, 32'hB000_0120, "rr_skip_a");
        b_get(0, 32'hB000_0100, "rr_skip_b");
        b_get(2, 32'hB000_0121, "rr_skip_c");
        @(posedge clk); @(negedge clk);
        checks++;
        if ({b_err, b_occupancy} !== 13'h0) begin failures++; $display("FAIL rr_final: got %h expected 0", {b_err, b_occupancy}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_stage_pc  = {16'h0300, 16'h0200, 16'h0100};
        b_stage_pc  = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        a_enq_valid = 1'b0; a_enq_stage = 2'd0; a_enq_data = 32'h0; a_req = 1'b0;
        b_enq_valid = 1'b0; b_enq_stage = 2'd0; b_enq_data = 32'h0; b_req = 1'b0;
        do_reset();
        test_reset();
        test_fixed_priority();
        test_bad_index();
        test_overflow();
        test_wrap_simul();
        test_empty_wait();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stage_work_scheduler.md
# stage_work_scheduler

Parametrised multi-stage work queue and scheduler between the GPU pipeline stages and the shader processor. It holds a FIFO of register-file snapshots per pipeline stage (transformation, lighting, projection, …). On processor request it selects a non-empty stage by fixed-priority or round-robin arbitration, pops one entry, and returns that stage's entry PC with the snapshot. Unlike a fixed three-queue scheduler, it generalises stage count, payload width and depth, waits instead of returning PC 0 when idle, and reports overflow and occupancy.

## Interface
Parameters:
- NUM_STAGES, 4, number of stage queues (2..8); index 0 = earliest pipeline stage
- DATA_W, 256, payload width (register snapshot)
- DEPTH, 16, entries per queue; power of two, ≥2
- PC_W, 16, program-counter width
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round robin
- SW = clog2(NUM_STAGES), CW = clog2(DEPTH)+1 (derived, not overridable)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- stage_pc  in  NUM_STAGES*PC_W  entry PC per stage; slice i = stage i
- enq_valid  in  1  enqueue strobe, one entry per cycle
- enq_stage  in  SW  target queue index
- enq_data  in  DATA_W  payload
- enq_ready  out  1  combinational: queue[enq_stage] not full and index valid
- req  in  1  processor requests work (level; held until grant_valid)
- grant_valid  out  1  one-cycle pulse: grant outputs valid
- grant_stage  out  SW  stage served
- grant_pc  out  PC_W  stage_pc slice of grant_stage, sampled at pick
- grant_data  out  DATA_W  popped payload
- busy  out  1  FSM not IDLE
- occupancy  out  NUM_STAGES*CW  per-queue entry count
- err  out  1  sticky: enqueue dropped (full queue or index ≥ NUM_STAGES)

## Operation
- Per queue: circular buffer, head/tail pointers of clog2(DEPTH) bits wrapping DEPTH-1→0, count 0..DEPTH.
- Enqueue: when enq_valid && enq_ready, write enq_data at tail, tail+1, count+1. When enq_valid && !enq_ready: drop, set err; no state change.
- FSM states: IDLE, PICK, RESP.
  - IDLE: if req and any count≠0 → PICK; latch winner; pop (head+1, count−1); register payload and PC. If req and all empty, stay IDLE (wait; never grant PC 0).
  - PICK → RESP unconditionally (payload registered to output).
  - RESP: grant_valid=1 for exactly this cycle → IDLE.
- Arbitration uses registered counts at the sampling edge.
  - RR_MODE=0: highest non-empty index.
  - RR_MODE=1: first non-empty index scanning downward from last_granted−1, wrapping NUM_STAGES−1. last_granted resets to 0, so first scan starts at NUM_STAGES−1.
- Enqueue and pop on the same queue in the same cycle: both take effect; count unchanged. Legal when full (pop frees the slot; enq_ready reflects pre-pop count, so it drops).
- An enqueue into an empty queue in the same cycle req is sampled is not seen until the next cycle.
- Non-winning queues are unaffected by a pop.

## Timing
- Reset values: all pointers/counts 0, FSM IDLE, grant_valid 0, grant_stage 0, grant_pc 0, grant_data 0, busy 0, err 0, occupancy 0, last_granted 0.
- Request latency: req high at edge t with a non-empty queue → grant_valid high in cycle t+2 (PICK at t+1, RESP at t+2).
- Back-to-back: next req is sampled at earliest in the cycle after RESP. Throughput is 1 grant / 3 cycles.
- occupancy reflects a pop from the edge entering PICK.
- grant_* hold their value after RESP until the next grant.
- rst asserted in any state: next edge returns to reset values. Any in-flight grant is discarded (no grant_valid) and all queued entries are lost.

## Test plan
- Reset: hold rst 2 cycles mid-PICK → grant_valid never pulses; occupancy 0; err 0; busy 0.
- Fixed priority (NUM_STAGES=3, stage_pc={0x300,0x200,0x100}): enqueue A→s0, B→s2; req → grant_stage=2, grant_pc=0x300, grant_data=B at t+2; second req → s0, A.
- Round robin (RR_MODE=1, 4 stages, 2 entries each): 8 reqs → stage order 3,2,1,0,3,2,1,0.
- Full/overflow (DEPTH=4): 5 enqueues to s1 → enq_ready low on the 5th; err=1; occupancy[s1]=4; four pops return entries in FIFO order.
- Wrap and simultaneous: with DEPTH=4, interleave 10 enqueues and pops on s0, including same-cycle enq+pop → data order preserved across pointer wrap; count never exceeds 4.
- Empty wait: req with all queues empty for 5 cycles → no grant, busy 0. Enqueue to s1 → grant of s1 two cycles after the entry is visible.
